nv_nvdla_sdp_wdma_layer_ctrl: RTL and testbench

Layer-level sequencer for the SDP write-DMA data path. It arms the path on `op_load` and latches the layer geometry. It counts completed DMA write commands against the expected line count, tracks outstanding write completions and throttles new commands at the outstanding limit. When the layer is finished it issues the done pulse and the interrupt pulse. It sits between the SDP register file, the WDMA data path and the DMA write port, and never touches payload data.

---
 rtl/nv_nvdla_sdp_wdma_pkg.sv | 26 ++
 rtl/nv_nvdla_sdp_wdma_outst_cnt.sv | 44 ++++
 rtl/nv_nvdla_sdp_wdma_layer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_nv_nvdla_sdp_wdma_layer_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_sdp_wdma_pkg.sv
// Shared types and constants for the SDP write-DMA layer controller.
package nv_nvdla_sdp_wdma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wdma_state_e;

  localparam int unsigned SDP_WDMA_EXP_W     = 18;
  // Line counters carry one extra bit so that the full 8192*32 = 2^18 product is representable.
  localparam int unsigned SDP_WDMA_CNT_W     = SDP_WDMA_EXP_W + 1;
  localparam int unsigned SDP_WDMA_MAX_OUTST = 32;

  // Expected number of write commands for a layer: (height+1)*(batch+1).
  function automatic logic [SDP_WDMA_CNT_W-1:0] calc_exp(input logic [12:0] height,
                                                         input logic [4:0]  batch);
    logic [SDP_WDMA_CNT_W-1:0] h1;
    logic [SDP_WDMA_CNT_W-1:0] b1;
    h1 = SDP_WDMA_CNT_W'(height) + SDP_WDMA_CNT_W'(1);
    b1 = SDP_WDMA_CNT_W'(batch) + SDP_WDMA_CNT_W'(1);
    calc_exp = SDP_WDMA_CNT_W'(h1 * b1);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_wdma_outst_cnt.sv
// Outstanding write-command counter: +1 per command end, -1 per completion.
// Never wraps; a completion with nothing outstanding is dropped and flagged.
module nv_nvdla_sdp_wdma_outst_cnt
  import nv_nvdla_sdp_wdma_pkg::*;
#(
  parameter  int unsigned MAX_OUTST = SDP_WDMA_MAX_OUTST,
  localparam int unsigned CW        = $clog2(MAX_OUTST) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic at_limit_o,
  output logic underflow_c_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count; simultaneous inc and dec cancel, both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o        = (cnt_q == '0);
  assign at_limit_o    = (cnt_q >= CW'(MAX_OUTST));
  assign underflow_c_o = dec_i & ~inc_i & (cnt_q == '0);

endmodule

// File: rtl/nv_nvdla_sdp_wdma_layer_ctrl.sv
// Layer sequencer for the SDP write-DMA path: arms on op_load, counts command
// ends against the layer geometry, throttles on outstanding completions and
// signals layer done plus interrupt.
// Optional stall counter output enabled by NVDLA_SDP_WDMA_PERF_EN.
module nv_nvdla_sdp_wdma_layer_ctrl
  import nv_nvdla_sdp_wdma_pkg::*;
#(
  parameter int unsigned MAX_OUTST = SDP_WDMA_MAX_OUTST
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        op_load,
  input  logic [12:0] reg2dp_height,
  input  logic [4:0]  reg2dp_batch_number,
  input  logic        reg2dp_interrupt_ptr,
  input  logic        dma_wr_req_vld,
  input  logic        dma_wr_req_rdy,
  input  logic        dma_wr_req_last,
  input  logic        dma_wr_rsp_complete,
  output logic        dat_en,
  output logic        dma_wr_cmd_allow,
  output logic        dp2reg_done,
  output logic        dp2reg_status_unequal,
  output logic        intr_req_pvld,
`ifdef NVDLA_SDP_WDMA_PERF_EN
  output logic [31:0] dp2reg_wdma_stall_cnt,
`endif
  output logic        intr_req_ptr
);

  wdma_state_e               state_q;
  wdma_state_e               state_d;
  logic [SDP_WDMA_CNT_W-1:0] exp_q;
  logic [SDP_WDMA_CNT_W-1:0] done_cnt_q;
  logic [SDP_WDMA_CNT_W-1:0] done_cnt_d;
  logic                      ptr_q;
  logic                      unequal_q;
  logic                      unequal_d;
  logic                      in_cmd_q;
  logic                      in_cmd_d;
  logic                      accept;
  logic                      cmd_end;
  logic                      load_ok;
  logic                      last_cmd;
  logic                      outst_zero;
  logic                      outst_at_limit;
  logic                      outst_udf;

  assign accept   = dma_wr_req_vld & dma_wr_req_rdy;
  assign cmd_end  = accept & dma_wr_req_last;
  assign load_ok  = op_load & (state_q == IDLE);
  assign last_cmd = cmd_end & ((done_cnt_q + SDP_WDMA_CNT_W'(1)) == exp_q);

  nv_nvdla_sdp_wdma_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst (
    .clk_i         (nvdla_core_clk),
    .rst_i         (nvdla_core_rst),
    .inc_i         (cmd_end),
    .dec_i         (dma_wr_rsp_complete),
    .zero_o        (outst_zero),
    .at_limit_o    (outst_at_limit),
    .underflow_c_o (outst_udf)
  );

  // State register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (op_load) state_d = RUN;
      RUN:     if (last_cmd) state_d = DRAIN;
      DRAIN:   if (outst_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state and counter registers.
  always_comb begin
    dat_en                = (state_q == RUN);
    dma_wr_cmd_allow      = (state_q == RUN) & (in_cmd_q | ~outst_at_limit);
    dp2reg_done           = (state_q == DONE);
    intr_req_pvld         = (state_q == DONE);
    dp2reg_status_unequal = unequal_q;
    intr_req_ptr          = ptr_q;
  end

  // Next values of the layer bookkeeping; a violation in the load cycle still sticks.
  always_comb begin
    done_cnt_d = done_cnt_q;
    unequal_d  = unequal_q;
    in_cmd_d   = in_cmd_q;
    if (load_ok) begin
      done_cnt_d = '0;
    end else if ((state_q == RUN) && cmd_end) begin
      done_cnt_d = done_cnt_q + SDP_WDMA_CNT_W'(1);
    end
    if (load_ok) begin
      unequal_d = 1'b0;
    end
    if (outst_udf || (accept && (state_q != RUN)) || (op_load && (state_q != IDLE))) begin
      unequal_d = 1'b1;
    end
    if (cmd_end) begin
      in_cmd_d = 1'b0;
    end else if (accept) begin
      in_cmd_d = 1'b1;
    end
  end

  // Layer bookkeeping registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      exp_q      <= '0;
      done_cnt_q <= '0;
      ptr_q      <= 1'b0;
      unequal_q  <= 1'b0;
      in_cmd_q   <= 1'b0;
    end else begin
      if (load_ok) begin
        exp_q <= calc_exp(reg2dp_height, reg2dp_batch_number);
        ptr_q <= reg2dp_interrupt_ptr;
      end
      done_cnt_q <= done_cnt_d;
      unequal_q  <= unequal_d;
      in_cmd_q   <= in_cmd_d;
    end
  end

`ifdef NVDLA_SDP_WDMA_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  // Saturating count of RUN cycles where the port back-pressures valid data.
  always_comb begin
    stall_d = stall_q;
    if (load_ok) begin
      stall_d = '0;
    end else if ((state_q == RUN) && dma_wr_req_vld && !dma_wr_req_rdy && (stall_q != '1)) begin
      stall_d = stall_q + 32'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign dp2reg_wdma_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_layer_ctrl.sv
// Scoreboard bench for the write-DMA layer controller (outstanding limit 4).
module tb_nv_nvdla_sdp_wdma_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_load = 1'b0;
  logic [12:0] height = '0;
  logic [4:0]  batch = '0;
  logic        iptr = 1'b0;
  logic        vld = 1'b0;
  logic        rdy = 1'b0;
  logic        lst = 1'b0;
  logic        rsp = 1'b0;
  logic        dat_en;
  logic        allow;
  logic        done;
  logic        unequal;
  logic        pvld;
  logic        ptr;
`ifdef NVDLA_SDP_WDMA_PERF_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct packed {
    logic ptr;
    logic uneq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_wdma_layer_ctrl #(
    .MAX_OUTST (4)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .op_load               (op_load),
    .reg2dp_height         (height),
    .reg2dp_batch_number   (batch),
    .reg2dp_interrupt_ptr  (iptr),
    .dma_wr_req_vld        (vld),
    .dma_wr_req_rdy        (rdy),
    .dma_wr_req_last       (lst),
    .dma_wr_rsp_complete   (rsp),
    .dat_en                (dat_en),
    .dma_wr_cmd_allow      (allow),
    .dp2reg_done           (done),
    .dp2reg_status_unequal (unequal),
    .intr_req_pvld         (pvld),
`ifdef NVDLA_SDP_WDMA_PERF_EN
    .dp2reg_wdma_stall_cnt (stall_cnt),
`endif
    .intr_req_ptr          (ptr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int h, input int b, input logic p);
    height  = 13'(h);
    batch   = 5'(b);
    iptr    = p;
    op_load = 1'b1;
    cyc(1);
    op_load = 1'b0;
  endtask

  task automatic beat(input logic last);
    vld = 1'b1;
    rdy = 1'b1;
    lst = last;
    cyc(1);
    vld = 1'b0;
    rdy = 1'b0;
    lst = 1'b0;
  endtask

  task automatic cpl();
    rsp = 1'b1;
    cyc(1);
    rsp = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"}, 32'({dat_en, allow, done, unequal, pvld, ptr}), 32'd0);
  endtask

  // Monitor: every done/interrupt presentation is matched against the next expected layer end.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || pvld) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=%0b pvld=%0b ptr=%0b uneq=%0b, none expected",
                   done, pvld, ptr, unequal);
        end else begin
          e = sb.pop_front();
          if ({done, pvld, ptr, unequal} !== {1'b1, 1'b1, e.ptr, e.uneq}) begin
            errors++;
            $display("FAIL layer_done: got done/pvld/ptr/uneq=%b expected %b",
                     {done, pvld, ptr, unequal}, {1'b1, 1'b1, e.ptr, e.uneq});
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc(1);

    // Layer 1: height=1 batch=0 -> 2 commands, completion 3 cycles after each cmd_end
    sb.push_back('{ptr: 1'b1, uneq: 1'b0});
    load(1, 0, 1'b1);
    chk("l1_dat_en", 32'(dat_en), 32'd1);
    chk("l1_allow", 32'(allow), 32'd1);
    beat(1'b1);
    cyc(2);
    cpl();
    beat(1'b1);
    chk("l1_drain_dat_en", 32'(dat_en), 32'd0);
    cyc(2);
    cpl();
    chk("l1_done_t1", 32'(done), 32'd0);
    cyc(1);
    chk("l1_done_t2", 32'(done), 32'd1);
    cyc(1);
    chk("l1_done_t3", 32'(done), 32'd0);
    chk("l1_unequal", 32'(unequal), 32'd0);

    // Layer 2: throttle at 4 outstanding, exp=6
    sb.push_back('{ptr: 1'b0, uneq: 1'b0});
    load(5, 0, 1'b0);
    for (int i = 0; i < 3; i++) beat(1'b1);
    chk("l2_allow_at3", 32'(allow), 32'd1);
    beat(1'b1);
    chk("l2_allow_at4", 32'(allow), 32'd0);
    cpl();
    chk("l2_allow_after_cpl", 32'(allow), 32'd1);
    beat(1'b0);
    chk("l2_allow_in_cmd", 32'(allow), 32'd1);
    beat(1'b0);
    beat(1'b1);
    chk("l2_allow_multi_end", 32'(allow), 32'd0);
    chk("l2_still_run", 32'(dat_en), 32'd1);
    for (int i = 0; i < 4; i++) cpl();
    chk("l2_allow_drained", 32'(allow), 32'd1);
    beat(1'b1);
    chk("l2_drain", 32'(dat_en), 32'd0);
    cpl();
    chk("l2_done_t1", 32'(done), 32'd0);
    cyc(1);
    chk("l2_done_t2", 32'(done), 32'd1);
    cyc(1);

    // Layer 3: height=2 batch=1 -> exp=6, same-cycle cmd_end and completion at outst=2
    sb.push_back('{ptr: 1'b1, uneq: 1'b0});
    load(2, 1, 1'b1);
    beat(1'b1);
    beat(1'b1);
    vld = 1'b1; rdy = 1'b1; lst = 1'b1; rsp = 1'b1;
    cyc(1);
    vld = 1'b0; rdy = 1'b0; lst = 1'b0; rsp = 1'b0;
    beat(1'b1);
    chk("l3_allow_outst3", 32'(allow), 32'd1);
    beat(1'b1);
    chk("l3_allow_outst4", 32'(allow), 32'd0);
    chk("l3_run_at5", 32'(dat_en), 32'd1);
    for (int i = 0; i < 4; i++) cpl();
    beat(1'b1);
    chk("l3_drain", 32'(dat_en), 32'd0);
    cpl();
    cyc(1);
    chk("l3_done", 32'(done), 32'd1);
    cyc(1);

    // Completion in IDLE with nothing outstanding
    cpl();
    chk("idle_cpl_unequal", 32'(unequal), 32'd1);
    sb.push_back('{ptr: 1'b0, uneq: 1'b0});
    load(0, 0, 1'b0);
    chk("load_clears_unequal", 32'(unequal), 32'd0);
    beat(1'b1);
    cpl();
    chk("l4_done_t1", 32'(done), 32'd0);
    cyc(1);
    chk("l4_done_t2", 32'(done), 32'd1);
    cyc(1);

    // op_load during RUN is ignored, then async reset in DRAIN
    load(1, 0, 1'b1);
    beat(1'b1);
    load(0, 0, 1'b0);
    chk("rerun_unequal", 32'(unequal), 32'd1);
    chk("rerun_still_run", 32'(dat_en), 32'd1);
    beat(1'b1);
    chk("rerun_drain", 32'(dat_en), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk_all_zero("post_rst");

`ifdef NVDLA_SDP_WDMA_PERF_EN
    // Stall counting in RUN only
    sb.push_back('{ptr: 1'b0, uneq: 1'b0});
    load(0, 0, 1'b0);
    vld = 1'b1;
    cyc(5);
    vld = 1'b0;
    chk("stall_run", stall_cnt, 32'd5);
    beat(1'b1);
    cpl();
    cyc(2);
    vld = 1'b1;
    cyc(3);
    vld = 1'b0;
    chk("stall_idle", stall_cnt, 32'd5);
`endif

    cyc(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
